// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller for a 5-stage RV32I core: stall/flush sequencing for
// load-use, redirects and data-memory waits, execute-stage forwarding selects, and
// saturating stall/flush performance counters.
module hazard_sequencer #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] Rs1D_i,
    input  logic [ADDR_W-1:0] Rs2D_i,
    input  logic [ADDR_W-1:0] Rs1E_i,
    input  logic [ADDR_W-1:0] Rs2E_i,
    input  logic [ADDR_W-1:0] RdE_i,
    input  logic              ResultSrcE_i,
    input  logic [ADDR_W-1:0] RdM_i,
    input  logic              RegWriteM_i,
    input  logic [ADDR_W-1:0] RdW_i,
    input  logic              RegWriteW_i,
    input  logic              PCSrcE_i,
    input  logic              MemBusyM_i,
    output logic              StallF_o,
    output logic              StallD_o,
    output logic              StallE_o,
    output logic              FlushD_o,
    output logic              FlushE_o,
    output logic [1:0]        ForwardAE_o,
    output logic [1:0]        ForwardBE_o,
    output logic              WaitTimeout_o,
    output logic [CNT_W-1:0]  StallCnt_o,
    output logic [CNT_W-1:0]  FlushCnt_o
);

    localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W:0]  WAIT_MAX = (WAIT_W + 1)'(MAX_WAIT);
    localparam logic [WAIT_W:0]  WAIT_ONE = (WAIT_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        StRun,
        StLoadStall,
        StRedirect,
        StMemWait
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    logic               w_lw;
    logic               w_pcsrc;
    logic               w_wait_tick;
    logic               w_wait_hit;
    logic [WAIT_W:0]    w_wait_inc;
    logic               w_stall_f;
    logic               w_stall_d;
    logic               w_stall_e;
    logic               w_flush_d;
    logic               w_flush_e;
    logic [1:0]         w_fwd_a;
    logic [1:0]         w_fwd_b;

    // Memory-stage result wins over writeback; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] rs);
        if (RegWriteM_i && (RdM_i != '0) && (RdM_i == rs)) begin
            return 2'b10;
        end else if (RegWriteW_i && (RdW_i != '0) && (RdW_i == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    // Forwarding selects and hazard sequencing (Mealy outputs, next state).
    always_comb begin
        w_fwd_a     = fwd_sel(Rs1E_i);
        w_fwd_b     = fwd_sel(Rs2E_i);
        w_lw        = ResultSrcE_i && (RdE_i != '0) && ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
        // Execute holds a flushed bubble right after a redirect.
        w_pcsrc     = PCSrcE_i && (r_state != StRedirect);
        w_wait_tick = (r_state == StMemWait) && MemBusyM_i;
        w_wait_inc  = {1'b0, r_wait_cnt} + WAIT_ONE;
        w_wait_hit  = w_wait_tick && (w_wait_inc == WAIT_MAX);
        w_stall_f   = 1'b0;
        w_stall_d   = 1'b0;
        w_stall_e   = 1'b0;
        w_flush_d   = 1'b0;
        w_flush_e   = 1'b0;
        w_next      = StRun;
        if (MemBusyM_i) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_next    = w_wait_hit ? StRun : StMemWait;
        end else if (w_pcsrc) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
            w_next    = StRedirect;
        end else if (w_lw) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
            w_next    = StLoadStall;
        end
    end

    // While reset is held the pipeline is frozen and flushed to NOPs.
    assign StallF_o      = rst_n & w_stall_f;
    assign StallD_o      = rst_n & w_stall_d;
    assign StallE_o      = rst_n & w_stall_e;
    assign FlushD_o      = ~rst_n | w_flush_d;
    assign FlushE_o      = ~rst_n | w_flush_e;
    assign ForwardAE_o   = rst_n ? w_fwd_a : 2'b00;
    assign ForwardBE_o   = rst_n ? w_fwd_b : 2'b00;
    assign WaitTimeout_o = r_timeout;
    assign StallCnt_o    = r_stall_cnt;
    assign FlushCnt_o    = r_flush_cnt;

    // FSM state, wait-cycle counter, sticky timeout and saturating perf counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StRun;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_wait_tick && !w_wait_hit) begin
                r_wait_cnt <= w_wait_inc[WAIT_W-1:0];
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_wait_hit) begin
                r_timeout <= 1'b1;
            end
            if (w_stall_f && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_flush_d && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: vector table, directed multi-cycle
// sequences, then randomized traffic against a behavioural model.
module tb_hazard_sequencer;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned MAX_WAIT = 15;
    localparam int unsigned CNT_W    = 6;
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic              ld, rwm, rww, pc, busy;
    logic              stall_f, stall_d, stall_e, flush_d, flush_e, timeout;
    logic [1:0]        fae, fbe;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    hazard_sequencer #(
        .ADDR_W  (ADDR_W),
        .MAX_WAIT(MAX_WAIT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Rs1D_i       (rs1d),
        .Rs2D_i       (rs2d),
        .Rs1E_i       (rs1e),
        .Rs2E_i       (rs2e),
        .RdE_i        (rde),
        .ResultSrcE_i (ld),
        .RdM_i        (rdm),
        .RegWriteM_i  (rwm),
        .RdW_i        (rdw),
        .RegWriteW_i  (rww),
        .PCSrcE_i     (pc),
        .MemBusyM_i   (busy),
        .StallF_o     (stall_f),
        .StallD_o     (stall_d),
        .StallE_o     (stall_e),
        .FlushD_o     (flush_d),
        .FlushE_o     (flush_e),
        .ForwardAE_o  (fae),
        .ForwardBE_o  (fbe),
        .WaitTimeout_o(timeout),
        .StallCnt_o   (stall_cnt),
        .FlushCnt_o   (flush_cnt)
    );

    always #5 clk = ~clk;

    // exp packing: {StallF, StallD, StallE, FlushD, FlushE, ForwardAE[1:0], ForwardBE[1:0]}
    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic       ld;
        logic [4:0] rdm;
        logic       rwm;
        logic [4:0] rdw;
        logic       rww, pc, busy;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[18];

    // Behavioural model state
    bit               m_last_redirect;
    int               m_busy_streak;
    bit               m_timeout;
    logic [CNT_W-1:0] m_stall_cnt;
    logic [CNT_W-1:0] m_flush_cnt;

    function automatic vec_t mk(input logic [4:0] a1d, a2d, a1e, a2e, ade, input logic l,
                                input logic [4:0] am, input logic wm, input logic [4:0] aw,
                                input logic ww, p, b, input logic [8:0] e);
        vec_t v;
        v.rs1d = a1d; v.rs2d = a2d; v.rs1e = a1e; v.rs2e = a2e; v.rde = ade; v.ld = l;
        v.rdm = am; v.rwm = wm; v.rdw = aw; v.rww = ww; v.pc = p; v.busy = b; v.exp = e;
        return v;
    endfunction

    function automatic logic [8:0] outs();
        return {stall_f, stall_d, stall_e, flush_d, flush_e, fae, fbe};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rs1d = v.rs1d; rs2d = v.rs2d; rs1e = v.rs1e; rs2e = v.rs2e; rde = v.rde; ld = v.ld;
        rdm = v.rdm; rwm = v.rwm; rdw = v.rdw; rww = v.rww; pc = v.pc; busy = v.busy;
    endtask

    task automatic clear_inputs();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'd0));
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_outs"}, 32'(outs()), 32'(9'b00011_00_00));
        check({name, "_cnts"}, 32'({stall_cnt, flush_cnt}), 32'd0);
        check({name, "_tmo"}, 32'(timeout), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_last_redirect = 0;
        m_busy_streak   = 0;
        m_timeout       = 0;
        m_stall_cnt     = '0;
        m_flush_cnt     = '0;
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (rwm && rdm != 0 && rdm == rs) return 2'd2;
        if (rww && rdw != 0 && rdw == rs) return 2'd1;
        return 2'd0;
    endfunction

    // Expected outputs from the pipeline rules, given current inputs and model history.
    task automatic model_step(output logic [8:0] e);
        bit load_use, redirect, s_f, s_d, s_e, f_d, f_e;
        load_use = ld && rde != 0 && (rde == rs1d || rde == rs2d);
        redirect = pc && !m_last_redirect;
        s_f = 0; s_d = 0; s_e = 0; f_d = 0; f_e = 0;
        if (busy) begin
            s_f = 1; s_d = 1; s_e = 1;
        end else if (redirect) begin
            f_d = 1; f_e = 1;
        end else if (load_use) begin
            s_f = 1; s_d = 1; f_e = 1;
        end
        e = {s_f, s_d, s_e, f_d, f_e, m_fwd(rs1e), m_fwd(rs2e)};
    endtask

    // Advance model history by one clock with the outputs just expected.
    task automatic model_advance(input logic [8:0] e);
        m_last_redirect = e[5];
        if (busy) begin
            // A busy run of 1 + MAX_WAIT cycles trips the timeout and restarts the window.
            m_busy_streak++;
            if (m_busy_streak == MAX_WAIT + 1) begin
                m_timeout     = 1;
                m_busy_streak = 0;
            end
        end else begin
            m_busy_streak = 0;
        end
        if (e[8] && m_stall_cnt != CNT_SAT) m_stall_cnt++;
        if (e[5] && m_flush_cnt != CNT_SAT) m_flush_cnt++;
    endtask

    int burst;

    initial begin
        logic [8:0] e;
        rst_n = 1'b0;
        clear_inputs();

        // ---------------- vector table ----------------
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b00000_00_00);
        tbl[1]  = mk(0, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 9'b11001_00_00);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b00000_00_00);
        tbl[3]  = mk(0, 0, 7, 0, 0, 0, 7, 1, 7, 1, 0, 0, 9'b00000_10_00);
        tbl[4]  = mk(0, 0, 7, 0, 0, 0, 7, 0, 7, 1, 0, 0, 9'b00000_01_00);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 7, 0, 7, 1, 0, 0, 9'b00000_00_00);
        tbl[6]  = mk(0, 0, 3, 3, 0, 0, 3, 1, 3, 1, 0, 0, 9'b00000_10_10);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 9'b00000_00_00);
        tbl[8]  = mk(0, 0, 6, 5, 0, 0, 5, 1, 6, 1, 0, 0, 9'b00000_01_10);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 9'b00000_00_00);
        tbl[10] = mk(9, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 9'b11001_00_00);
        tbl[11] = mk(9, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 9'b00000_00_00);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 9'b00011_00_00);
        tbl[13] = mk(0, 4, 0, 0, 4, 1, 0, 0, 0, 0, 1, 0, 9'b11001_00_00);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 9'b00011_00_00);
        tbl[15] = mk(0, 4, 0, 0, 4, 1, 0, 0, 0, 0, 1, 1, 9'b11100_00_00);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 9'b00011_00_00);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b00000_00_00);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check($sformatf("tbl%0d", i), 32'(outs()), 32'(tbl[i].exp));
            @(posedge clk);
            #1;
        end
        clear_inputs();
        @(negedge clk);
        check("tbl_stallcnt", 32'(stall_cnt), 32'd4);
        check("tbl_flushcnt", 32'(flush_cnt), 32'd3);

        // ---------------- redirect held two cycles ----------------
        do_reset();
        pc = 1'b1;
        @(negedge clk);
        check("redir_first", 32'(outs()), 32'(9'b00011_00_00));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("redir_second", 32'(outs()), 32'(9'b00000_00_00));
        @(posedge clk);
        #1 pc = 1'b0;
        @(negedge clk);
        check("redir_flushcnt", 32'(flush_cnt), 32'd1);

        // ---------------- memory busy held 20 cycles ----------------
        do_reset();
        busy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("busy%0d_outs", k), 32'(outs()), 32'(9'b11100_00_00));
            check($sformatf("busy%0d_tmo", k), 32'(timeout), 32'(k >= 16));
            @(posedge clk);
            #1;
        end
        busy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("tmo_sticky", 32'(timeout), 32'd1);
            @(posedge clk);
            #1;
        end
        check("busy_stallcnt", 32'(stall_cnt), 32'd20);

        // ---------------- busy + redirect + load-use together ----------------
        do_reset();
        drive(mk(0, 4, 0, 0, 4, 1, 0, 0, 0, 0, 1, 1, 9'd0));
        @(negedge clk);
        check("combo_stall", 32'(outs()), 32'(9'b11100_00_00));
        @(posedge clk);
        #1 busy = 1'b0;
        @(negedge clk);
        check("combo_release", 32'(outs()), 32'(9'b00011_00_00));
        @(posedge clk);
        #1 pc = 1'b0;
        @(negedge clk);
        check("combo_loaduse", 32'(outs()), 32'(9'b11001_00_00));
        check("combo_flushcnt", 32'(flush_cnt), 32'd1);
        @(posedge clk);
        #1;

        // ---------------- reset dropped mid-wait ----------------
        do_reset();
        busy = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        rs1e = 7; rdm = 7; rwm = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_state("midwait_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_inputs();
        @(negedge clk);
        check("postreset_run", 32'(outs()), 32'(9'b00000_00_00));
        @(posedge clk);
        #1 busy = 1'b1;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            check($sformatf("rewait%0d_tmo", k), 32'(timeout), 32'(k >= 16));
            @(posedge clk);
            #1;
        end

        // ---------------- randomized traffic vs model ----------------
        do_reset();
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                burst = 0;
                continue;
            end
            rs1d = 5'($urandom_range(0, 3)); rs2d = 5'($urandom_range(0, 3));
            rs1e = 5'($urandom_range(0, 3)); rs2e = 5'($urandom_range(0, 3));
            rde  = 5'($urandom_range(0, 3)); rdm  = 5'($urandom_range(0, 3));
            rdw  = 5'($urandom_range(0, 3));
            ld   = 1'($urandom_range(0, 1)); rwm = 1'($urandom_range(0, 1));
            rww  = 1'($urandom_range(0, 1)); pc  = ($urandom_range(0, 3) == 0);
            if (burst > 0) begin
                busy = 1'b1;
                burst--;
            end else if ($urandom_range(0, 11) == 0) begin
                busy  = 1'b1;
                burst = $urandom_range(0, 24);
            end else begin
                busy = 1'b0;
            end
            @(negedge clk);
            model_step(e);
            check("rand_outs", 32'(outs()), 32'(e));
            check("rand_stallcnt", 32'(stall_cnt), 32'(m_stall_cnt));
            check("rand_flushcnt", 32'(flush_cnt), 32'(m_flush_cnt));
            check("rand_tmo", 32'(timeout), 32'(m_timeout));
            model_advance(e);
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
